trojan_alu_sync: RTL and testbench

//  Registered 4-op ALU (add/sub/and/or) with zero and carry flags, one-cycle latency.

---
 rtl/trojan_alu_sync.sv | 95 +++++++++
 tb/tb_trojan_alu_sync.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/trojan_alu_sync.sv
// Registered 4-op ALU (add/sub/and/or) with zero/carry flags and one-cycle latency.
// Define TROJAN_EN to compile in the rare-input trigger that corrupts the OR result.
module trojan_alu_sync #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TRIG_A       = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0] TRIG_B       = WIDTH'(8'h5A),
    parameter logic [WIDTH-1:0] PAYLOAD_MASK = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    logic [WIDTH-1:0] y_d, y_q;
    logic             carry_d, carry_q;
    logic             zero_d, zero_q;
    logic             valid_q;
    logic [WIDTH:0]   sum;
    logic             trig;

    assign sum = {1'b0, a} + {1'b0, b};

`ifdef TROJAN_EN
    // Stateless trigger: only the exact operand pair on an OR fires it.
    assign trig = in_valid && (op_e'(opcode) == OP_OR) && (a == TRIG_A) && (b == TRIG_B);
`else
    assign trig = 1'b0;
`endif

    always_comb begin
        y_d     = '0;
        carry_d = 1'b0;
        case (op_e'(opcode))
            OP_ADD: begin
                y_d     = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            OP_SUB: begin
                y_d     = a - b;
                carry_d = (a < b);
            end
            OP_AND: y_d = a & b;
            OP_OR: begin
`ifdef TROJAN_EN
                y_d = trig ? ((a | b) ^ PAYLOAD_MASK) : (a | b);
`else
                y_d = a | b;
`endif
            end
            default: y_d = '0;
        endcase
        // zero tracks the final result, payload included
        zero_d = (y_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                y_q     <= y_d;
                zero_q  <= zero_d;
                carry_q <= carry_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign carry     = carry_q;

    // trig is unused in the clean build; keep it referenced for lint
    logic unused_trig;
    assign unused_trig = trig;

endmodule

// File: tb/tb_trojan_alu_sync.sv
// Scoreboard bench for trojan_alu_sync; expectations follow TROJAN_EN when defined.
module tb_trojan_alu_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a, b;
    logic [1:0] opcode;
    logic       out_valid;
    logic [7:0] y;
    logic       zero, carry;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] y;
        logic       z;
        logic       c;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;

    trojan_alu_sync #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .opcode(opcode), .out_valid(out_valid), .y(y), .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [7:0] ma, input logic [7:0] mb);
        exp_t     e;
        logic [8:0] s;
        e = '0;
        case (op)
            2'b00: begin s = ma + mb; e.y = s[7:0]; e.c = s[8]; end
            2'b01: begin e.y = ma - mb; e.c = (ma < mb); end
            2'b10: e.y = ma & mb;
            default: begin
                e.y = ma | mb;
`ifdef TROJAN_EN
                if (ma == 8'hA5 && mb == 8'h5A) e.y = 8'h00;
`endif
            end
        endcase
        e.z = (e.y == 8'h00);
        return e;
    endfunction

    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] ta, input logic [7:0] tb_);
        exp_t e;
        in_valid = v; opcode = op; a = ta; b = tb_;
        if (v) exp_q.push_back(model(op, ta, tb_));
        @(posedge clk); #1;
        chk("out_valid", out_valid, v);
        if (v) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("y", y, e.y);
                chk("zero", zero, e.z);
                chk("carry", carry, e.c);
                last = e;
            end
        end else begin
            chk("hold_y", y, last.y);
            chk("hold_zero", zero, last.z);
            chk("hold_carry", carry, last.c);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; opcode = '0;
        last = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_zero", zero, 0);
        chk("rst_carry", carry, 0);
        rst_n = 1'b1;

        step(1, 2'b00, 8'h0A, 8'h03);
        step(1, 2'b01, 8'h0F, 8'h07);
        step(1, 2'b01, 8'h03, 8'h05);
        step(1, 2'b10, 8'hF0, 8'h0F);
        step(1, 2'b11, 8'hAA, 8'h55);
        step(1, 2'b11, 8'hA5, 8'h5A);
        step(1, 2'b00, 8'hA5, 8'h5A);
        step(1, 2'b01, 8'hA5, 8'h5A);
        step(1, 2'b10, 8'hA5, 8'h5A);
        step(1, 2'b11, 8'hA5, 8'h5B);
        step(1, 2'b11, 8'hA4, 8'h5A);
        step(1, 2'b00, 8'hFF, 8'h01);
        step(0, 2'b11, 8'hA5, 8'h5A);
        step(0, 2'b00, 8'h12, 8'h34);
        step(1, 2'b01, 8'h00, 8'hFF);
        step(1, 2'b00, 8'h80, 8'h80);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin ra = 8'hA5; rb = 8'h5A; end
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), ra, rb);
        end

        // Reset between edges with a result pending and one already showing
        step(1, 2'b00, 8'h11, 8'h22);
        in_valid = 1'b1; opcode = 2'b00; a = 8'hFF; b = 8'hFF;
        exp_q.push_back(model(2'b00, 8'hFF, 8'hFF));
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        last = '0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_zero", zero, 0);
        chk("mid_rst_carry", carry, 0);
        @(posedge clk); #1;
        chk("held_rst_valid", out_valid, 0);
        chk("held_rst_y", y, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step(1, 2'b00, 8'h0A, 8'h03);
        step(0, 2'b00, 8'h00, 8'h00);

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
